// File: rtl/alu_dispatch_ctrl.sv
// alu_dispatch_ctrl: issue-side FSM that accepts one instruction, reads its sources,
// drives the ALU for the required cycles and writes the result back to the register file.
module alu_dispatch_ctrl #(
  parameter int WORD_SIZE   = 19,
  parameter int OPC_W       = 5,
  parameter int REG_ADDR_W  = 3,
  parameter int MULDIV_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [WORD_SIZE-1:0]  instr,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] rf_raddr_1,
  output logic [REG_ADDR_W-1:0] rf_raddr_2,
  input  logic [WORD_SIZE-1:0]  rf_rdata_1,
  input  logic [WORD_SIZE-1:0]  rf_rdata_2,
  output logic [OPC_W-1:0]      alu_opcode,
  output logic [WORD_SIZE-1:0]  alu_op_1,
  output logic [WORD_SIZE-1:0]  alu_op_2,
  input  logic [WORD_SIZE-1:0]  alu_result,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic                  busy,
  output logic                  illegal_op
);
  localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_INC = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_DEC = OPC_W'(10);
  localparam int RD_HI  = WORD_SIZE - OPC_W - 1;
  localparam int RS1_HI = RD_HI - REG_ADDR_W;
  localparam int RS2_HI = RS1_HI - REG_ADDR_W;
  localparam int LOW_W  = RS2_HI - REG_ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WB} state_t;

  state_t                state_q;
  logic [OPC_W-1:0]      opc_q;
  logic [OPC_W-1:0]      alu_opcode_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [REG_ADDR_W-1:0] raddr_1_q;
  logic [REG_ADDR_W-1:0] raddr_2_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [WORD_SIZE-1:0]  op_1_q;
  logic [WORD_SIZE-1:0]  op_2_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [2:0]            cnt_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  we_q;
  logic                  illegal_q;

  logic [OPC_W-1:0]      in_opc;
  logic [LOW_W-1:0]      unused_low;
  logic                  in_legal;
  logic                  unary;
  logic                  muldiv;
  logic                  wb_d;
  logic [WORD_SIZE-1:0]  op_2_d;

  assign in_opc     = instr[WORD_SIZE-1 -: OPC_W];
  assign unused_low = instr[LOW_W-1:0];
  assign in_legal   = in_opc inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD,
                                     OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC};
  assign unary      = opc_q inside {OP_NOT, OP_INC, OP_DEC};
  assign muldiv     = opc_q inside {OP_MUL, OP_DIV};
  assign op_2_d     = unary ? '0 : rf_rdata_2;
  // Result is captured on the last ALU cycle: EXEC for single-cycle ops, final WAIT otherwise.
  assign wb_d       = (state_q == EXEC && !(muldiv && MULDIV_WAIT > 0)) ||
                      (state_q == WAIT && cnt_q == 3'd0);

  // Register read data arrives in EXEC, so operands pass straight through then and are held in WAIT.
  assign alu_op_1    = state_q == EXEC ? rf_rdata_1 : state_q == WAIT ? op_1_q : '0;
  assign alu_op_2    = state_q == EXEC ? op_2_d : state_q == WAIT ? op_2_q : '0;
  assign alu_opcode  = alu_opcode_q;
  assign rf_raddr_1  = raddr_1_q;
  assign rf_raddr_2  = raddr_2_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign illegal_op  = illegal_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      opc_q        <= '0;
      alu_opcode_q <= '0;
      rd_q         <= '0;
      raddr_1_q    <= '0;
      raddr_2_q    <= '0;
      waddr_q      <= '0;
      op_1_q       <= '0;
      op_2_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      raddr_1_q <= '0;
      raddr_2_q <= '0;
      we_q      <= wb_d;
      waddr_q   <= wb_d ? rd_q : '0;
      wdata_q   <= wb_d ? alu_result : '0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (instr_valid && ready_q) begin
            if (in_legal) begin
              state_q   <= READ;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              opc_q     <= in_opc;
              rd_q      <= instr[RD_HI -: REG_ADDR_W];
              raddr_1_q <= instr[RS1_HI -: REG_ADDR_W];
              raddr_2_q <= instr[RS2_HI -: REG_ADDR_W];
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        READ: begin
          state_q      <= EXEC;
          alu_opcode_q <= opc_q;
        end
        EXEC: begin
          op_1_q <= rf_rdata_1;
          op_2_q <= op_2_d;
          cnt_q  <= 3'(MULDIV_WAIT - 1);
          state_q <= wb_d ? WB : WAIT;
          alu_opcode_q <= wb_d ? '0 : alu_opcode_q;
        end
        WAIT: begin
          cnt_q   <= cnt_q - 3'd1;
          state_q <= wb_d ? WB : WAIT;
          alu_opcode_q <= wb_d ? '0 : alu_opcode_q;
        end
        WB: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// tb_alu_dispatch_ctrl: directed test-plan sequence followed by random traffic and resets,
// checked every cycle against a timeline model of accept/read/exec/writeback events.
module tb_alu_dispatch_ctrl;
  localparam int MW = 2;
  localparam logic [4:0] OP_NOT = 5'h01, OP_AND = 5'h02, OP_OR  = 5'h03, OP_XOR = 5'h04,
                         OP_ADD = 5'h05, OP_SUB = 5'h06, OP_MUL = 5'h07, OP_DIV = 5'h08,
                         OP_INC = 5'h09, OP_DEC = 5'h0A;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, rf_we, busy, illegal_op;
  logic [18:0] instr, rf_rdata_1, rf_rdata_2, alu_op_1, alu_op_2, alu_result, rf_wdata;
  logic [2:0]  rf_raddr_1, rf_raddr_2, rf_waddr;
  logic [4:0]  alu_opcode;

  alu_dispatch_ctrl #(.MULDIV_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr_1(rf_raddr_1), .rf_raddr_2(rf_raddr_2),
    .rf_rdata_1(rf_rdata_1), .rf_rdata_2(rf_rdata_2), .alu_opcode(alu_opcode),
    .alu_op_1(alu_op_1), .alu_op_2(alu_op_2), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] alu_f(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
    case (op)
      OP_NOT: return ~a;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return (b == 19'd0) ? '1 : a / b;
      OP_INC: return a + 19'd1;
      OP_DEC: return a - 19'd1;
      default: return '0;
    endcase
  endfunction

  function automatic bit legal_f(input logic [4:0] op);
    return op inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC};
  endfunction

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 5'd0};
  endfunction

  // Environment: registered-read register file and a combinational ALU
  logic [18:0] regs [8];
  always @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    rf_rdata_1 <= regs[rf_raddr_1];
    rf_rdata_2 <= regs[rf_raddr_2];
  end
  assign alu_result = alu_f(alu_opcode, alu_op_1, alu_op_2);

  int          cyc, n_chk, n_pass, acc_at, free_at, ill_at, m_w;
  bit          rst_now, rst_done;
  logic [4:0]  m_op;
  logic [2:0]  m_rd, m_rs1, m_rs2;
  logic [18:0] m_a, m_b, m_res;
  logic [18:0] mrf [8];
  logic [18:0] dq [$];
  logic [4:0]  legal_ops [10] = '{OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC};
  logic [18:0] init_v [8] = '{19'd0, 19'd5, 19'd7, 19'd0, 19'd3, 19'd4, 19'd1, 19'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      regs[i] = init_v[i];
      mrf[i]  = init_v[i];
    end
    reset = 1'b0; instr_valid = 1'b0; instr = '0;
    n_chk = 0; n_pass = 0; acc_at = -100; free_at = 0; ill_at = -1; m_w = 0;
    m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_a = '0; m_b = '0; m_res = '0;
    rst_done = 1'b0;
    dq = '{mk(OP_ADD, 3, 1, 2), mk(OP_ADD, 3, 1, 2), mk(OP_ADD, 3, 1, 2),
           mk(OP_SUB, 7, 0, 6), mk(OP_NOT, 7, 0, 0), mk(OP_MUL, 7, 4, 5),
           mk(5'h1F, 7, 1, 2), mk(OP_ADD, 3, 1, 2)};
    repeat (2) @(posedge clk);
    rst_now = 1'b1;
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      bit live, exe, wb, ready_e, rst_in, v;
      logic [18:0] ins;
      logic [4:0] op;
      @(negedge clk);
      live    = acc_at >= 0;
      ready_e = !rst_now && cyc >= free_at;
      exe     = live && cyc >= acc_at + 2 && cyc <= acc_at + 2 + m_w;
      wb      = live && cyc == acc_at + 3 + m_w;
      chk("instr_ready", instr_ready, ready_e);
      chk("busy", busy, live && cyc > acc_at && cyc < free_at);
      chk("illegal_op", illegal_op, cyc == ill_at);
      chk("rf_raddr_1", rf_raddr_1, (live && cyc == acc_at + 1) ? m_rs1 : 3'd0);
      chk("rf_raddr_2", rf_raddr_2, (live && cyc == acc_at + 1) ? m_rs2 : 3'd0);
      chk("alu_opcode", alu_opcode, exe ? m_op : 5'd0);
      chk("alu_op_1", alu_op_1, exe ? m_a : 19'd0);
      chk("alu_op_2", alu_op_2, exe ? m_b : 19'd0);
      chk("rf_we", rf_we, wb);
      chk("rf_waddr", rf_waddr, wb ? m_rd : 3'd0);
      chk("rf_wdata", rf_wdata, wb ? m_res : 19'd0);
      if (wb) mrf[m_rd] = m_res;
      rst_in = k >= 3;
      v = 1'b0;
      ins = 19'($urandom);
      if (k >= 3 && dq.size() > 0) begin
        v = 1'b1;
        ins = dq[0];
      end else if (k >= 3) begin
        if (!rst_done && live && cyc == acc_at + 2) begin
          rst_in = 1'b0;
          rst_done = 1'b1;
        end else begin
          rst_in = $urandom_range(0, 149) != 0;
        end
        v = $urandom_range(0, 2) != 0;
        op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 9)];
        ins = {op, 14'($urandom)};
      end
      reset = rst_in;
      instr_valid = v;
      instr = ins;
      if (!rst_in) begin
        acc_at = -100; free_at = 0; ill_at = -1;
      end else if (v && ready_e) begin
        if (k >= 3 && dq.size() > 0) void'(dq.pop_front());
        if (legal_f(ins[18:14])) begin
          acc_at = cyc;
          m_op = ins[18:14]; m_rd = ins[13:11]; m_rs1 = ins[10:8]; m_rs2 = ins[7:5];
          m_a = mrf[m_rs1];
          m_b = (m_op inside {OP_NOT, OP_INC, OP_DEC}) ? 19'd0 : mrf[m_rs2];
          m_res = alu_f(m_op, m_a, m_b);
          m_w = (m_op inside {OP_MUL, OP_DIV}) ? MW : 0;
          free_at = cyc + 4 + m_w;
        end else begin
          ill_at = cyc + 1;
        end
      end
      rst_now = !rst_in;
      @(posedge clk);
      cyc++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_dispatch_ctrl.md
# alu_dispatch_ctrl

Issue-side controller for the ALU: drives the ALU control bus (opcode) and operand lines.
- Accepts one 19-bit instruction at a time over a valid/ready handshake.
- Decodes it, reads both source registers from the register file, and presents opcode and operands to the ALU.
- Holds them for the required number of cycles, then writes the ALU result back to the destination register.
- Sits between instruction fetch and the ALU/register file; it replaces ad-hoc opcode driving in the datapath top.

## Interface
- WORD_SIZE, 19, data/instruction width (from constants package)
- OPC_W, 5, opcode field width
- REG_ADDR_W, 3, register address width (8 registers)
- MULDIV_WAIT, 2, extra EXEC cycles held for MUL and DIV (0..7)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction present
- instr  in  WORD_SIZE  instruction word: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] ignored
- instr_ready  out  1  block can accept an instruction
- rf_raddr_1, rf_raddr_2  out  REG_ADDR_W  register file read addresses
- rf_rdata_1, rf_rdata_2  in  WORD_SIZE  read data, valid one cycle after address (registered read)
- alu_opcode  out  OPC_W  drives control_bus_if OPCODE
- alu_op_1, alu_op_2  out  WORD_SIZE  ALU operand inputs
- alu_result  in  WORD_SIZE  ALU result, combinational from opcode/operands
- rf_we  out  1  register write enable, one-cycle pulse
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  WORD_SIZE  write data
- busy  out  1  high in every state except IDLE
- illegal_op  out  1  one-cycle pulse on rejected opcode

## Operation
- Legal opcodes (symbolic, from opcodes package): NOT, AND, OR, XOR, ADD, SUB, MUL, DIV, INC, DEC. All others are illegal.
- FSM states: IDLE, READ, EXEC, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid, latch opcode/rd/rs1/rs2.
  - Legal opcode: go to READ.
  - Illegal opcode: stay IDLE; illegal_op=1 next cycle; no write.
- READ: rf_raddr_1=rs1, rf_raddr_2=rs2. Go to EXEC.
- EXEC: latch rf_rdata into alu_op_1/alu_op_2 registers visible this cycle; drive alu_opcode.
  - NOT, INC, DEC: alu_op_2 forced to 0.
  - MUL/DIV with MULDIV_WAIT>0: go to WAIT. Otherwise capture alu_result into rf_wdata and go to WB.
- WAIT: opcode and operands held stable. Count MULDIV_WAIT cycles, capture alu_result on the last one, then go to WB.
- WB: rf_we=1, rf_waddr=rd, rf_wdata=captured result. Go to IDLE.
- alu_opcode=0 and alu_op_1/2=0 outside EXEC/WAIT, so the ALU default output is 0.
- Width: result is written as delivered (WORD_SIZE, modulo 2^19). The block does no sign or overflow handling.
- rd equal to rs1/rs2 is legal: operands are already latched before WB.

## Timing
- Reset (reset=0 at a clock edge): state IDLE; all outputs 0, including instr_ready. instr_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: the instruction is abandoned, with no rf_we and no illegal_op.
- Acceptance at cycle 0 (instr_valid & instr_ready).
  - READ in cycle 1, EXEC in cycle 2, rf_we in cycle 3.
  - MUL/DIV: rf_we in cycle 3+MULDIV_WAIT.
- Throughput: one instruction per 4 cycles (4+MULDIV_WAIT for MUL/DIV). instr_ready returns high the cycle after WB.
- instr_valid while busy is ignored. instr is not sampled until IDLE.
- Illegal opcode: illegal_op pulses in cycle 1; instr_ready stays 1; the next instruction can be accepted in cycle 1.
- busy=1 from cycle 1 through the WB cycle inclusive.

## Test plan
- Bench setup: regfile model with r1=5, r2=7. ADD rd=3 accepted at cycle 0 -> rf_raddr 1/2 in cycle 1; alu_opcode=ADD, alu_op_1=5, alu_op_2=7 in cycle 2; rf_we=1, rf_waddr=3, rf_wdata=12 in cycle 3.
- SUB with r1=0, r2=1 -> rf_wdata=19'h7FFFF; NOT r1=19'h00000 -> alu_op_2=0, rf_wdata=19'h7FFFF.
- MUL with MULDIV_WAIT=2, r1=3, r2=4 -> opcode/operands stable cycles 2-4, rf_we in cycle 5 with wdata=12; instr_ready=0 cycles 1-5.
- Opcode 5'h1F -> illegal_op=1 in cycle 1, no rf_we, instr_ready=1; following ADD is accepted in cycle 1.
- instr_valid held high continuously with back-to-back ADDs -> acceptances at cycles 0, 4, 8; exactly one rf_we per instruction.
- reset=0 during EXEC -> no rf_we, all outputs 0 next cycle, instr_ready=1 the cycle after reset releases.
